ram_fifo_ctrl: RTL and testbench

- Stream-side controller that sits directly upstream of the team's 128x8 single-port scratch RAM.
- Turns a valid/ready push stream and a valid/ready pop stream into single-cycle RAM read/write commands (cs, read, write, 7-bit address, write data).
- Reuses the RAM's registered read_data as the FIFO output register.
- The RAM does one operation per cycle, so this block arbitrates between push and pop traffic and tracks pointers, occupancy and full/empty.

---
 rtl/ram_fifo_pkg.sv | 8 +
 rtl/ram_fifo_ctrl_if.sv | 22 ++
 rtl/ram_fifo_ptr.sv | 34 +++
 rtl/ram_fifo_ctrl.sv | 72 +++++++
 tb/tb_ram_fifo_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared sizing for the FIFO controller that fronts the 128x8 single-port scratch RAM.
// CNT_W is one bit wider than the address because occupancy reaches DEPTH+1.
package ram_fifo_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push and pop valid/ready streams of the RAM-backed FIFO.
// The master modport is the producer/consumer side; the slave modport is the controller.
interface ram_fifo_ctrl_if;
  import ram_fifo_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ram_fifo_ptr.sv
// Write/read pointers and RAM-region occupancy for the FIFO controller.
// Pointers wrap by natural overflow; read and write never issue in the same cycle.
module ram_fifo_ptr
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_issue,
  input  logic              rd_issue,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0]  ram_cnt,
  output logic              full,
  output logic              cnt_zero
);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (wr_issue) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_issue, rd_issue})
        2'b10:   ram_cnt <= ram_cnt + CNT_W'(1);
        2'b01:   ram_cnt <= ram_cnt - CNT_W'(1);
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  assign full     = (ram_cnt == CNT_W'(DEPTH));
  assign cnt_zero = (ram_cnt == '0);
endmodule

// File: rtl/ram_fifo_ctrl.sv
// Stream-to-RAM FIFO controller; the RAM's registered read data doubles as the head register.
// Optional FIFO_FLUSH_EN adds a synchronous flush input that clears the FIFO like rst.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef FIFO_FLUSH_EN
  input  logic              flush,
`endif
  ram_fifo_ctrl_if.slave    s,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              ram_cs,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data
);
  logic              clr;
  logic              out_valid_q;
  logic              head_free;
  logic              rd_issue;
  logic              wr_issue;
  logic              cnt_zero;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  ram_cnt;

`ifdef FIFO_FLUSH_EN
  assign clr = rst | flush;
`else
  assign clr = rst;
`endif

  // Refilling the head wins the single RAM port; the producer stalls that cycle.
  assign head_free  = !out_valid_q || s.out_ready;
  assign rd_issue   = head_free && !cnt_zero && !clr;
  assign s.in_ready = !full && !rd_issue && !clr;
  assign wr_issue   = s.in_valid && s.in_ready;

  assign ram_read       = rd_issue;
  assign ram_write      = wr_issue;
  assign ram_cs         = rd_issue || wr_issue;
  assign ram_address    = rd_issue ? rd_ptr : wr_ptr;
  assign ram_write_data = s.in_data;

  ram_fifo_ptr u_ptr (
    .clk      (clk),
    .rst      (clr),
    .wr_issue (wr_issue),
    .rd_issue (rd_issue),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .ram_cnt  (ram_cnt),
    .full     (full),
    .cnt_zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (clr)                           out_valid_q <= 1'b0;
    else if (rd_issue)                 out_valid_q <= 1'b1;
    else if (out_valid_q && s.out_ready) out_valid_q <= 1'b0;
  end

  assign s.out_valid = out_valid_q;
  assign s.out_data  = ram_read_data;
  assign count       = ram_cnt + CNT_W'(out_valid_q);
  assign empty       = (count == '0);
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 128x8 registered-read RAM.
// Flush steps run only when FIFO_FLUSH_EN is defined.
module tb_ram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst;
`ifdef FIFO_FLUSH_EN
  logic       flush;
`endif
  logic [7:0] count;
  logic       full, empty;
  logic       ram_cs, ram_read, ram_write;
  logic [6:0] ram_address;
  logic [7:0] ram_write_data;
  logic [7:0] ram_read_data;
  logic [7:0] mem [128];
  int         collide = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q [$];

  ram_fifo_ctrl_if bus ();

  ram_fifo_ctrl dut (
    .clk            (clk),
    .rst            (rst),
`ifdef FIFO_FLUSH_EN
    .flush          (flush),
`endif
    .s              (bus),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .ram_cs         (ram_cs),
    .ram_read       (ram_read),
    .ram_write      (ram_write),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs && ram_write) mem[ram_address] <= ram_write_data;
    if (ram_cs && ram_read)  ram_read_data <= mem[ram_address];
    if (ram_read && ram_write) collide <= collide + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("push_timeout", 32'(bus.in_ready), 32'd1);
    q.push_back(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] exp;
    int         n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
`ifdef FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    tick();
    // reset: producer offered a word, must be refused
    bus.in_valid = 1'b1;
    bus.in_data = 8'h77;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_ram_cs", 32'(ram_cs), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);

    // single push of 0xA5
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    #1;
    chk("p1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("p1_write", 32'(ram_write), 32'd1);
    chk("p1_read", 32'(ram_read), 32'd0);
    chk("p1_wr_addr", 32'(ram_address), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("p1_rd_strobe", 32'(ram_read), 32'd1);
    chk("p1_rd_addr", 32'(ram_address), 32'd0);
    chk("p1_count_a", 32'(count), 32'd1);
    chk("p1_ov_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("p1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("p1_out_data", 32'(bus.out_data), 32'hA5);
    chk("p1_count_b", 32'(count), 32'd1);
    tick();
    chk("p1_count_c", 32'(count), 32'd1);
    chk("p1_idle_cs", 32'(ram_cs), 32'd0);

    // fill to 129 words
    do_reset();
    for (int i = 0; i < 129; i++) begin
      push(8'(i));
      if (i == 127) begin
        #1;
        chk("fill128_full", 32'(full), 32'd0);
        chk("fill128_count", 32'(count), 32'd128);
      end
    end
    #1;
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd129);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_head_valid", 32'(bus.out_valid), 32'd1);
    chk("full_head_data", 32'(bus.out_data), 32'h00);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hFF;
    #1;
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_write", 32'(ram_write), 32'd0);
    tick();
    tick();
    chk("stall_count", 32'(count), 32'd129);
    bus.in_valid = 1'b0;

    // drain from full, one pop per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 129; i++) begin
      #1;
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_data", 32'(bus.out_data), 32'(i));
      if (i == 127) begin
        chk("wrap_rd", 32'(ram_read), 32'd1);
        chk("wrap_addr", 32'(ram_address), 32'd0);
      end
      tick();
    end
    #1;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // simultaneous push and pop streaming
    do_reset();
    push(8'h10);
    push(8'h11);
    push(8'h12);
    bus.out_ready = 1'b1;
    d = 8'h13;
    for (int c = 0; c < 40; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data = d;
      #1;
      chk("stream_count", 32'(count), 32'(q.size()));
      if (bus.out_valid && q.size() != 0) begin
        exp = q.pop_front();
        chk("stream_data", 32'(bus.out_data), 32'(exp));
      end
      if (bus.in_ready) begin
        q.push_back(d);
        d = d + 8'd1;
      end
      tick();
    end
    chk("stream_accepted", 32'(d), 32'h26);
    bus.in_valid = 1'b0;
    n = 0;
    while (count != 0 && n < 300) begin
      #1;
      if (bus.out_valid && q.size() != 0) begin
        exp = q.pop_front();
        chk("stream_drain_data", 32'(bus.out_data), 32'(exp));
      end
      tick();
      n++;
    end
    #1;
    chk("stream_end_count", 32'(count), 32'd0);
    chk("stream_model_left", 32'(q.size()), 32'd0);
    chk("no_rd_wr_overlap", 32'(collide), 32'd0);

    // reset with 50 words stored
    do_reset();
    for (int i = 0; i < 50; i++) push(8'(8'h40 + i));
    #1;
    chk("r50_count", 32'(count), 32'd50);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h99;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("r50_count_clr", 32'(count), 32'd0);
    chk("r50_out_valid", 32'(bus.out_valid), 32'd0);
    chk("r50_empty", 32'(empty), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h3C;
    #1;
    chk("r50_wr", 32'(ram_write), 32'd1);
    chk("r50_wr_addr", 32'(ram_address), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("r50_rd_addr", 32'(ram_address), 32'd0);
    tick();
    chk("r50_rb_valid", 32'(bus.out_valid), 32'd1);
    chk("r50_rb_data", 32'(bus.out_data), 32'h3C);

`ifdef FIFO_FLUSH_EN
    // flush with 10 stored and a word offered
    do_reset();
    for (int i = 0; i < 10; i++) push(8'(i));
    #1;
    chk("fl_count_pre", 32'(count), 32'd10);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hEE;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fl_ram_cs", 32'(ram_cs), 32'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    push(8'h55);
    tick();
    chk("fl_rb_data", 32'(bus.out_data), 32'h55);
    chk("fl_rb_count", 32'(count), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
